// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants and types.
//   Parameter-set sizes (k, omega) for ML-DSA-44/65/87.
//   hint_pack_state_t : FSM states of hint_bit_pack.
//   HINT_BYTES(k, omega) : length in bytes of the packed hint string.
package mldsa_pkg;

    localparam int unsigned MLDSA44_K     = 4;
    localparam int unsigned MLDSA44_OMEGA = 80;
    localparam int unsigned MLDSA65_K     = 6;
    localparam int unsigned MLDSA65_OMEGA = 55;
    localparam int unsigned MLDSA87_K     = 8;
    localparam int unsigned MLDSA87_OMEGA = 75;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } hint_pack_state_t;

    // Position list (omega bytes) followed by one cumulative count per row.
    function automatic int unsigned HINT_BYTES(input int unsigned k, input int unsigned omega);
        return omega + k;
    endfunction

endpackage

// File: rtl/hint_bit_pack.sv
// ML-DSA HintBitPack: encodes k 256-bit hint polynomials into the (omega+k)-byte
// hint string, scanning one coefficient per clock.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : begin packing (accepted only in IDLE)
//   h[K]          : hint bits, h[i][j] = coefficient j of polynomial i; stable until done
//   y             : packed string, byte b at y[8b +: 8] (bit 8b is the byte MSB)
//   busy          : high while scanning
//   done          : one-cycle completion pulse (normal or error)
//   valid, error  : result status, held until the next accepted start
module hint_bit_pack
    import mldsa_pkg::*;
#(
    parameter int unsigned K     = MLDSA87_K,
    parameter int unsigned OMEGA = MLDSA87_OMEGA
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [0:255]                        h [K],
    output logic [0:HINT_BYTES(K, OMEGA)*8-1]   y,
    output logic                                busy,
    output logic                                done,
    output logic                                valid,
    output logic                                error
);

    localparam int unsigned NBYTES = HINT_BYTES(K, OMEGA);
    localparam int unsigned YW     = NBYTES * 8;
    localparam int unsigned IW     = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned AW     = $clog2(YW);

    hint_pack_state_t  state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [7:0]        idx_q, idx_d;
    logic [0:YW-1]     y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    logic              hit;
    logic [7:0]        idx_inc;
    logic [AW-1:0]     list_base;
    logic [AW-1:0]     cnt_base;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Next-state, byte-write decode and status
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        idx_d     = idx_q;
        y_d       = y_q;
        valid_d   = valid_q;
        error_d   = error_q;
        done_d    = 1'b0;

        hit       = h[i_q][j_q];
        idx_inc   = idx_q + 8'(hit);
        // Byte offsets of the next list slot and of this row's cumulative count
        list_base = AW'({idx_q, 3'b000});
        cnt_base  = AW'((OMEGA + 32'(i_q)) * 32'd8);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    y_d     = '0;
                    valid_d = 1'b0;
                    error_d = 1'b0;
                    i_d     = '0;
                    j_d     = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (hit && (idx_q == 8'(OMEGA))) begin
                    // One set bit too many: abandon the scan, keep what was written
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    if (hit) begin
                        y_d[list_base +: 8] = j_q;
                        idx_d               = idx_inc;
                    end
                    if (j_q == 8'd255) begin
                        y_d[cnt_base +: 8] = idx_inc;
                        i_d                = i_q + IW'(1);
                        if (i_q == IW'(K - 1)) begin
                            state_d = FINISH;
                        end
                    end
                    j_d = j_q + 8'd1;
                end
            end

            FINISH: begin
                done_d  = 1'b1;
                valid_d = ~error_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SCAN);
    end

    assign y     = y_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign error = error_q;

endmodule

// File: tb/tb_hint_bit_pack.sv
// Self-checking bench for hint_bit_pack (k=8, omega=75): directed table,
// random hint patterns against a reference HintBitPack/HintBitUnpack model,
// reset mid-scan and start-while-busy sequences.
module tb_hint_bit_pack;

    localparam int K     = 8;
    localparam int OMEGA = 75;
    localparam int NB    = OMEGA + K;
    localparam int YW    = NB * 8;
    localparam int NCOEF = K * 256;
    localparam int TMO   = NCOEF + 200;

    typedef logic [0:255] hrow_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    hrow_t         h [K];
    logic [0:YW-1] y;
    logic          busy, done, valid, error;

    int n_checks = 0;
    int n_errors = 0;

    hint_bit_pack #(.K(K), .OMEGA(OMEGA)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .h     (h),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .error (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ybyte(input int b);
        return int'(y[8*b +: 8]);
    endfunction

    // Reference HintBitPack: list of set positions, per-row running totals,
    // abort when the (omega+1)-th set bit is met.
    function automatic void model(input hrow_t hm [K], output logic [0:YW-1] ye,
                                  output bit ev, output bit ee, output int elat);
        int  b [NB];
        int  cnt;
        bit  stop;
        for (int t = 0; t < NB; t++) b[t] = 0;
        cnt  = 0;
        stop = 0;
        ee   = 0;
        elat = NCOEF + 1;
        for (int i = 0; i < K && !stop; i++) begin
            for (int j = 0; j < 256 && !stop; j++) begin
                if (hm[i][j]) begin
                    if (cnt == OMEGA) begin
                        ee   = 1;
                        stop = 1;
                        elat = i * 256 + j + 2;
                    end else begin
                        b[cnt] = j;
                        cnt++;
                    end
                end
            end
            if (!stop) b[OMEGA + i] = cnt;
        end
        ev = !ee;
        for (int t = 0; t < NB; t++) ye[8*t +: 8] = 8'(b[t]);
    endfunction

    // Reference HintBitUnpack; returns 1 when the string is well formed.
    function automatic bit unpack(input logic [0:YW-1] yi, output hrow_t ho [K]);
        int idx, first, v;
        idx = 0;
        for (int i = 0; i < K; i++) ho[i] = '0;
        for (int i = 0; i < K; i++) begin
            v = int'(yi[8*(OMEGA+i) +: 8]);
            if (v < idx || v > OMEGA) return 0;
            first = idx;
            while (idx < v) begin
                if (idx > first && yi[8*(idx-1) +: 8] >= yi[8*idx +: 8]) return 0;
                ho[i][yi[8*idx +: 8]] = 1'b1;
                idx++;
            end
        end
        for (int t = idx; t < OMEGA; t++) begin
            if (yi[8*t +: 8] != 8'd0) return 0;
        end
        return 1;
    endfunction

    task automatic clear_h();
        for (int i = 0; i < K; i++) h[i] = '0;
    endtask

    task automatic set_random(input int w);
        int n, r, c;
        clear_h();
        n = 0;
        while (n < w) begin
            r = int'($urandom_range(0, K - 1));
            c = int'($urandom_range(0, 255));
            if (!h[r][c]) begin
                h[r][c] = 1'b1;
                n++;
            end
        end
    endtask

    // Pulse start; lat = clock edges after the sampling edge until done is seen.
    task automatic run_pack(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_pack(input string tag, input int lat);
        logic [0:YW-1] ye;
        bit            ev, ee;
        int            elat;
        model(h, ye, ev, ee, elat);
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " valid"}, 64'(valid), 64'(ev));
        chk({tag, " error"}, 64'(error), 64'(ee));
        chk({tag, " busy_with_done"}, 64'(busy), 64'd0);
        n_checks++;
        if (y !== ye) begin
            n_errors++;
            for (int t = 0; t < NB; t++) begin
                if (y[8*t +: 8] !== ye[8*t +: 8]) begin
                    $display("FAIL %s y: byte %0d got %0d expected %0d", tag, t,
                             y[8*t +: 8], ye[8*t +: 8]);
                    break;
                end
            end
        end
        @(negedge clk);
        chk({tag, " done_single_pulse"}, 64'(done), 64'd0);
        chk({tag, " valid_held"}, 64'(valid), 64'(ev));
    endtask

    typedef struct {
        int npos;
        int pr [3];
        int pc [3];
        int ck_b [5];
        int ck_v [5];
        bit ev;
        bit ee;
        int elat;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int            lat, w, dones, done_lat, overlap;
        bit            ok, same;
        hrow_t         hr [K];
        logic [0:YW-1] ye;
        bit            ev, ee;
        int            elat;

        // Directed vectors
        vecs[0].npos = 0;
        vecs[0].pr = '{0, 0, 0};    vecs[0].pc = '{0, 0, 0};
        vecs[0].ck_b = '{0, 1, 74, 75, 82};  vecs[0].ck_v = '{0, 0, 0, 0, 0};
        vecs[0].ev = 1; vecs[0].ee = 0; vecs[0].elat = 2049;
        vecs[1].npos = 1;
        vecs[1].pr = '{0, 0, 0};    vecs[1].pc = '{5, 0, 0};
        vecs[1].ck_b = '{0, 1, 74, 75, 82};  vecs[1].ck_v = '{5, 0, 0, 1, 1};
        vecs[1].ev = 1; vecs[1].ee = 0; vecs[1].elat = 2049;
        vecs[2].npos = 3;
        vecs[2].pr = '{1, 1, 7};    vecs[2].pc = '{3, 200, 255};
        vecs[2].ck_b = '{0, 1, 2, 75, 82};   vecs[2].ck_v = '{3, 200, 255, 0, 3};
        vecs[2].ev = 1; vecs[2].ee = 0; vecs[2].elat = 2049;

        rst   = 1'b1;
        start = 1'b0;
        clear_h();
        #12;
        chk("reset y_zero", 64'(y == '0), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset valid", 64'(valid), 64'd0);
        chk("reset error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 3; v++) begin
            clear_h();
            for (int p = 0; p < vecs[v].npos; p++) h[vecs[v].pr[p]][vecs[v].pc[p]] = 1'b1;
            run_pack(lat);
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'(vecs[v].elat));
            chk($sformatf("vec%0d valid", v), 64'(valid), 64'(vecs[v].ev));
            chk($sformatf("vec%0d error", v), 64'(error), 64'(vecs[v].ee));
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("vec%0d byte%0d", v, vecs[v].ck_b[c]),
                    64'(ybyte(vecs[v].ck_b[c])), 64'(vecs[v].ck_v[c]));
            end
            check_pack($sformatf("vec%0d", v), lat);
        end

        // Exactly omega set bits: still valid
        set_random(OMEGA);
        run_pack(lat);
        chk("w75 byte82", 64'(ybyte(82)), 64'd75);
        chk("w75 valid", 64'(valid), 64'd1);
        check_pack("w75", lat);

        // omega+1 set bits: error, early completion
        set_random(OMEGA + 1);
        run_pack(lat);
        chk("w76 error", 64'(error), 64'd1);
        chk("w76 valid", 64'(valid), 64'd0);
        chk("w76 early_done", 64'(lat < NCOEF + 1), 64'd1);
        check_pack("w76", lat);

        // Random round trips through HintBitUnpack
        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(0, OMEGA));
            set_random(w);
            run_pack(lat);
            check_pack($sformatf("rnd%0d", r), lat);
            ok = unpack(y, hr);
            chk($sformatf("rnd%0d unpack_ok", r), 64'(ok), 64'd1);
            same = 1;
            for (int i = 0; i < K; i++) if (hr[i] !== h[i]) same = 0;
            chk($sformatf("rnd%0d roundtrip", r), 64'(same), 64'd1);
        end

        // Random overloads
        for (int r = 0; r < 2; r++) begin
            set_random(int'($urandom_range(OMEGA + 1, OMEGA + 45)));
            run_pack(lat);
            check_pack($sformatf("ovl%0d", r), lat);
        end

        // Asynchronous reset in the middle of a scan
        set_random(30);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (999) @(negedge clk);
        chk("midscan busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midscan y_zero", 64'(y == '0), 64'd1);
        chk("midscan busy", 64'(busy), 64'd0);
        chk("midscan done", 64'(done), 64'd0);
        chk("midscan valid", 64'(valid), 64'd0);
        chk("midscan error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        set_random(int'($urandom_range(1, OMEGA)));
        run_pack(lat);
        check_pack("after_reset", lat);

        // start pulses during SCAN and during FINISH are ignored
        set_random(40);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones    = 0;
        done_lat = -1;
        overlap  = 0;
        for (int n = 1; n <= 2300; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (done_lat < 0) done_lat = n;
            end
            if (done === 1'b1 && busy === 1'b1) overlap++;
            start = (n == 50 || n == 2048) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        model(h, ye, ev, ee, elat);
        chk("restart done_count", 64'(dones), 64'd1);
        chk("restart latency", 64'(done_lat), 64'(elat));
        chk("restart done_busy_overlap", 64'(overlap), 64'd0);
        chk("restart valid", 64'(valid), 64'(ev));
        chk("restart y_match", 64'(y == ye), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
